// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the data-memory port arbiter.
package mem_arb_pkg;

  localparam int ADDR_W_DEF       = 32;
  localparam int DATA_W_DEF       = 32;
  localparam int TAG_W_DEF        = 6;
  localparam int STARVE_LIMIT_DEF = 4;
  localparam int ALIGN_MAX_W      = 64;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    ST_REQ  = 2'd1,
    LD_REQ  = 2'd2,
    LD_WAIT = 2'd3
  } arb_state_e;

  // Operates on a wide container so any address width up to 64 can be cast in and out.
  function automatic logic [ALIGN_MAX_W-1:0] word_align(input logic [ALIGN_MAX_W-1:0] a);
    return {a[ALIGN_MAX_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/mem_arb_pick.sv
// Load/store priority select with a saturating store-starvation counter.
// Readies are combinational from valids and idle; the counter updates on accept strobes.
module mem_arb_pick
  import mem_arb_pkg::*;
#(
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic ld_valid,
  input  logic st_valid,
  input  logic st_urgent,
  input  logic flush,
  input  logic idle,
  input  logic ld_acc,
  input  logic st_acc,
  output logic ld_ready,
  output logic st_ready
);

  localparam int CNT_W = $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] LIMIT_C = CNT_W'(STARVE_LIMIT);

  logic [CNT_W-1:0] starve_q, starve_d;
  logic             st_prio;
  logic             st_sel;
  logic             ld_sel;

  assign st_prio = st_urgent || (starve_q == LIMIT_C);
  assign st_sel  = st_valid && (st_prio || !ld_valid);
  assign ld_sel  = ld_valid && !(st_valid && st_prio);

  // A selected load is still refused during flush; the store does not take its slot.
  assign st_ready = idle && st_sel;
  assign ld_ready = idle && ld_sel && !flush;

  always_comb begin
    starve_d = starve_q;
    if (st_acc) begin
      starve_d = '0;
    end else if (ld_acc && st_valid && (starve_q != LIMIT_C)) begin
      starve_d = starve_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
    end else begin
      starve_q <= starve_d;
    end
  end

endmodule

// File: rtl/mem_port_arbiter.sv
// Single data-memory port shared by EX loads and committed stores; request/grant/response sequencing.
// Store accept->st_done >= 2 cycles, load accept->ld_done_valid >= 3; requesters stall (ready=0) while busy.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int TAG_W        = TAG_W_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                flush,
  input  logic                ld_valid,
  output logic                ld_ready,
  input  logic [ADDR_W-1:0]   ld_addr,
  input  logic [TAG_W-1:0]    ld_tag,
  input  logic                st_valid,
  output logic                st_ready,
  input  logic                st_urgent,
  input  logic [ADDR_W-1:0]   st_addr,
  input  logic [DATA_W-1:0]   st_data,
  input  logic [DATA_W/8-1:0] st_be,
  output logic                mem_req,
  output logic                mem_we,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  output logic [DATA_W/8-1:0] mem_be,
  input  logic                mem_gnt,
  input  logic                mem_rvalid,
  input  logic [DATA_W-1:0]   mem_rdata,
  output logic                ld_done_valid,
  output logic [TAG_W-1:0]    ld_done_tag,
  output logic [DATA_W-1:0]   ld_done_data,
  output logic                st_done,
  output logic                busy
);

  localparam int BE_W = DATA_W / 8;

  arb_state_e        state_q;
  logic              mem_req_q;
  logic              mem_we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [BE_W-1:0]   be_q;
  logic [TAG_W-1:0]  tag_q;
  logic              kill_q;
  logic              ld_done_vld_q;
  logic [TAG_W-1:0]  ld_done_tag_q;
  logic [DATA_W-1:0] ld_done_dat_q;
  logic              st_done_q;

  logic idle;
  logic ld_acc;
  logic st_acc;

  assign idle   = (state_q == IDLE);
  assign ld_acc = ld_valid && ld_ready;
  assign st_acc = st_valid && st_ready;

  mem_arb_pick #(
    .STARVE_LIMIT(STARVE_LIMIT)
  ) u_pick (
    .clk      (clk),
    .rst      (rst),
    .ld_valid (ld_valid),
    .st_valid (st_valid),
    .st_urgent(st_urgent),
    .flush    (flush),
    .idle     (idle),
    .ld_acc   (ld_acc),
    .st_acc   (st_acc),
    .ld_ready (ld_ready),
    .st_ready (st_ready)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      mem_req_q     <= 1'b0;
      mem_we_q      <= 1'b0;
      addr_q        <= '0;
      wdata_q       <= '0;
      be_q          <= '0;
      tag_q         <= '0;
      kill_q        <= 1'b0;
      ld_done_vld_q <= 1'b0;
      ld_done_tag_q <= '0;
      ld_done_dat_q <= '0;
      st_done_q     <= 1'b0;
    end else begin
      ld_done_vld_q <= 1'b0;
      st_done_q     <= 1'b0;
      case (state_q)
        IDLE: begin
          kill_q <= 1'b0;
          if (st_acc) begin
            addr_q    <= ADDR_W'(word_align(ALIGN_MAX_W'(st_addr)));
            wdata_q   <= st_data;
            be_q      <= st_be;
            mem_req_q <= 1'b1;
            mem_we_q  <= 1'b1;
            state_q   <= ST_REQ;
          end else if (ld_acc) begin
            addr_q    <= ADDR_W'(word_align(ALIGN_MAX_W'(ld_addr)));
            be_q      <= '1;
            tag_q     <= ld_tag;
            mem_req_q <= 1'b1;
            mem_we_q  <= 1'b0;
            state_q   <= LD_REQ;
          end
        end
        ST_REQ: begin
          if (mem_gnt) begin
            mem_req_q <= 1'b0;
            mem_we_q  <= 1'b0;
            st_done_q <= 1'b1;
            state_q   <= IDLE;
          end
        end
        LD_REQ: begin
          // The request stays up through a flush; the kill flag discards the result instead.
          if (flush) begin
            kill_q <= 1'b1;
          end
          if (mem_gnt) begin
            mem_req_q <= 1'b0;
            state_q   <= LD_WAIT;
          end
        end
        LD_WAIT: begin
          if (mem_rvalid) begin
            ld_done_vld_q <= !(kill_q || flush);
            ld_done_tag_q <= tag_q;
            ld_done_dat_q <= mem_rdata;
            kill_q        <= 1'b0;
            state_q       <= IDLE;
          end else if (flush) begin
            kill_q <= 1'b1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign mem_req       = mem_req_q;
  assign mem_we        = mem_we_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign mem_be        = be_q;
  assign ld_done_valid = ld_done_vld_q;
  assign ld_done_tag   = ld_done_tag_q;
  assign ld_done_data  = ld_done_dat_q;
  assign st_done       = st_done_q;
  assign busy          = (state_q != IDLE);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Randomized bench for mem_port_arbiter: transaction-level model predicts accepts, memory ops and completions.
`timescale 1ns/1ps
module tb_mem_port_arbiter;

  localparam int LIMIT    = 4;
  localparam int N_CYC    = 3000;
  localparam int DRAIN_AT = 2600;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        ld_valid, ld_ready;
  logic [31:0] ld_addr;
  logic [5:0]  ld_tag;
  logic        st_valid, st_ready, st_urgent;
  logic [31:0] st_addr, st_data;
  logic [3:0]  st_be;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_gnt, mem_rvalid;
  logic [31:0] mem_rdata;
  logic        ld_done_valid;
  logic [5:0]  ld_done_tag;
  logic [31:0] ld_done_data;
  logic        st_done, busy;

  mem_port_arbiter #(
    .ADDR_W(32), .DATA_W(32), .TAG_W(6), .STARVE_LIMIT(LIMIT)
  ) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_addr(ld_addr), .ld_tag(ld_tag),
    .st_valid(st_valid), .st_ready(st_ready), .st_urgent(st_urgent),
    .st_addr(st_addr), .st_data(st_data), .st_be(st_be),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_be(mem_be), .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .ld_done_valid(ld_done_valid), .ld_done_tag(ld_done_tag), .ld_done_data(ld_done_data),
    .st_done(st_done), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
  } mem_op_t;

  typedef struct {
    int          cyc;
    logic [5:0]  tag;
    logic [31:0] data;
  } ld_exp_t;

  mem_op_t exp_mem[$];
  ld_exp_t exp_ld[$];
  int      exp_st[$];

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s @cycle %0d: got 0x%0h required 0x%0h", name, cyc, act, exp);
  endtask

  // Model: outstanding 0=none, 1=store wants grant, 2=load wants grant, 3=load awaits data.
  int          outst  = 0;
  int          starve = 0;
  logic        killed = 1'b0;
  logic [5:0]  cur_tag;
  logic        ld_pend = 1'b0, st_pend = 1'b0;
  logic [31:0] p_ld_addr, p_st_addr, p_st_data;
  logic [5:0]  p_ld_tag;
  logic [3:0]  p_st_be;

  // Monitor: compares memory-side handshakes and completion pulses against the queues.
  initial begin
    forever begin
      @(posedge clk);
      #3;
      if (mem_req === 1'b1 && mem_gnt === 1'b1) begin
        if (exp_mem.size() == 0) begin
          chk("mem_op_unexpected", {63'd0, mem_req}, 64'd0);
        end else begin
          mem_op_t e;
          e = exp_mem.pop_front();
          chk("mem_we", {63'd0, mem_we}, {63'd0, e.we});
          chk("mem_addr", {32'd0, mem_addr}, {32'd0, e.addr});
          chk("mem_be", {60'd0, mem_be}, {60'd0, e.be});
          if (e.we) chk("mem_wdata", {32'd0, mem_wdata}, {32'd0, e.data});
        end
      end
      while (exp_ld.size() != 0 && exp_ld[0].cyc < cyc) begin
        chk("ld_done_missing_cycle", 64'(cyc), 64'(exp_ld[0].cyc));
        void'(exp_ld.pop_front());
      end
      if (ld_done_valid === 1'b1) begin
        if (exp_ld.size() == 0) begin
          chk("ld_done_spurious", {63'd0, ld_done_valid}, 64'd0);
        end else begin
          ld_exp_t e;
          e = exp_ld.pop_front();
          chk("ld_done_cycle", 64'(cyc), 64'(e.cyc));
          chk("ld_done_tag", {58'd0, ld_done_tag}, {58'd0, e.tag});
          chk("ld_done_data", {32'd0, ld_done_data}, {32'd0, e.data});
        end
      end
      while (exp_st.size() != 0 && exp_st[0] < cyc) begin
        chk("st_done_missing_cycle", 64'(cyc), 64'(exp_st[0]));
        void'(exp_st.pop_front());
      end
      if (st_done === 1'b1) begin
        if (exp_st.size() == 0) begin
          chk("st_done_spurious", {63'd0, st_done}, 64'd0);
        end else begin
          chk("st_done_cycle", 64'(cyc), 64'(exp_st.pop_front()));
        end
      end
    end
  end

  // Stimulus + reference model: drive at +1, observe the values the next edge will see at +2.
  initial begin
    int   p_ld, p_st, p_urg, p_fl, p_rst;
    int   exp_acc, act_acc;
    logic draining;
    rst = 1'b1; flush = 1'b0; ld_valid = 1'b0; ld_addr = '0; ld_tag = '0;
    st_valid = 1'b0; st_urgent = 1'b0; st_addr = '0; st_data = '0; st_be = '0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_mem_req", {63'd0, mem_req}, 64'd0);
    chk("reset_busy", {63'd0, busy}, 64'd0);
    chk("reset_ld_done", {63'd0, ld_done_valid}, 64'd0);
    chk("reset_st_done", {63'd0, st_done}, 64'd0);
    rst = 1'b0;

    for (int i = 0; i < N_CYC; i++) begin
      case (i / 650)
        0:       begin p_ld = 100; p_st = 100; p_urg = 0;  p_fl = 0;  p_rst = 0;  end
        1:       begin p_ld = 70;  p_st = 60;  p_urg = 40; p_fl = 0;  p_rst = 0;  end
        2:       begin p_ld = 60;  p_st = 50;  p_urg = 15; p_fl = 25; p_rst = 0;  end
        default: begin p_ld = 60;  p_st = 50;  p_urg = 15; p_fl = 15; p_rst = 20; end
      endcase
      draining = (i >= DRAIN_AT);
      @(posedge clk);
      #1;
      rst = !draining && (outst == 2) && ($urandom_range(0, 99) < p_rst);
      if (!ld_pend && !draining && $urandom_range(0, 99) < p_ld) begin
        ld_pend = 1'b1; p_ld_addr = $urandom; p_ld_tag = 6'($urandom_range(0, 63));
      end
      if (!st_pend && !draining && $urandom_range(0, 99) < p_st) begin
        st_pend = 1'b1; p_st_addr = $urandom; p_st_data = $urandom;
        p_st_be = 4'($urandom_range(0, 15));
      end
      ld_valid  = ld_pend && !rst;
      ld_addr   = p_ld_addr;
      ld_tag    = p_ld_tag;
      st_valid  = st_pend && !rst;
      st_addr   = p_st_addr;
      st_data   = p_st_data;
      st_be     = p_st_be;
      st_urgent = ($urandom_range(0, 99) < p_urg);
      flush     = !draining && ($urandom_range(0, 99) < p_fl);
      mem_gnt   = !rst && (outst == 1 || outst == 2) && ($urandom_range(0, 2) != 0);
      mem_rdata = $urandom;
      if (outst == 3) mem_rvalid = ($urandom_range(0, 1) == 1);
      else            mem_rvalid = !rst && ($urandom_range(0, 7) == 0);
      #1;

      chk("mem_req_level", {63'd0, mem_req}, {63'd0, (outst == 1 || outst == 2)});
      chk("busy_level", {63'd0, busy}, {63'd0, (outst != 0)});
      if (rst) begin
        outst = 0; starve = 0; killed = 1'b0;
        exp_mem.delete();
        continue;
      end

      if (outst == 0) begin
        exp_acc = 0;
        if (st_valid && (st_urgent || starve == LIMIT || !ld_valid)) exp_acc = 2;
        else if (ld_valid && !flush) exp_acc = 1;
      end else begin
        exp_acc = 0;
      end
      act_acc = 0;
      if (ld_valid && ld_ready) act_acc += 1;
      if (st_valid && st_ready) act_acc += 2;
      chk("accept_choice", 64'(act_acc), 64'(exp_acc));

      if (outst == 0) begin
        if (exp_acc == 2) begin
          exp_mem.push_back('{we: 1'b1, addr: {st_addr[31:2], 2'b00}, data: st_data, be: st_be});
          outst = 1; starve = 0; st_pend = 1'b0;
        end else if (exp_acc == 1) begin
          exp_mem.push_back('{we: 1'b0, addr: {ld_addr[31:2], 2'b00}, data: 32'd0, be: 4'hF});
          outst = 2; cur_tag = ld_tag; killed = 1'b0; ld_pend = 1'b0;
          if (st_valid && starve < LIMIT) starve++;
        end
      end else if (outst == 1) begin
        if (mem_gnt) begin
          exp_st.push_back(cyc + 1);
          outst = 0;
        end
      end else if (outst == 2) begin
        if (flush) killed = 1'b1;
        if (mem_gnt) outst = 3;
      end else begin
        if (flush) killed = 1'b1;
        if (mem_rvalid) begin
          if (!killed) exp_ld.push_back('{cyc: cyc + 1, tag: cur_tag, data: mem_rdata});
          outst = 0;
        end
      end
    end

    rst = 1'b0; ld_valid = 1'b0; st_valid = 1'b0; flush = 1'b0;
    mem_gnt = 1'b0; mem_rvalid = 1'b0;
    repeat (3) @(posedge clk);
    #4;
    chk("drain_outstanding", 64'(outst), 64'd0);
    chk("drain_mem_queue", 64'(exp_mem.size()), 64'd0);
    chk("drain_ld_queue", 64'(exp_ld.size()), 64'd0);
    chk("drain_st_queue", 64'(exp_st.size()), 64'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Owns the single data-memory port behind the EX/MEM stage.
- Arbitrates between speculative loads from the EX stage and committed stores from the store buffer.
- Sequences each memory transaction: request, grant, then response for loads.
- Returns load results tagged with the ROB tag, and kills in-flight load results on pipeline flush.

Parameters:
- ADDR_W, 32, address width
- DATA_W, 32, data width
- TAG_W, 6, ROB tag width
- STARVE_LIMIT, 4, consecutive load grants allowed while a store waits

Ports:
- clk  in  1  clock, all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- flush  in  1  pipeline flush; kills loads not yet completed
- ld_valid  in  1  load request from EX
- ld_ready  out  1  load accepted when ld_valid&&ld_ready
- ld_addr  in  ADDR_W  load byte address
- ld_tag  in  TAG_W  ROB tag of the load
- st_valid  in  1  committed store from store buffer
- st_ready  out  1  store accepted when st_valid&&st_ready
- st_urgent  in  1  store buffer nearly full; store wins arbitration
- st_addr  in  ADDR_W  store byte address
- st_data  in  DATA_W  store data
- st_be  in  DATA_W/8  store byte enables
- mem_req  out  1  memory request
- mem_we  out  1  1 = write
- mem_addr  out  ADDR_W  word-aligned address ({addr[ADDR_W-1:2],2'b00})
- mem_wdata  out  DATA_W  write data
- mem_be  out  DATA_W/8  byte enables; all ones for loads
- mem_gnt  in  1  memory accepted the request this cycle
- mem_rvalid  in  1  read data valid
- mem_rdata  in  DATA_W  read data
- ld_done_valid  out  1  one-cycle pulse: load result valid
- ld_done_tag  out  TAG_W  tag of the completed load
- ld_done_data  out  DATA_W  raw word read
- st_done  out  1  one-cycle pulse: store accepted by memory
- busy  out  1  state != IDLE

Behaviour:
- FSM states: IDLE, ST_REQ, LD_REQ, LD_WAIT.
- Reset (rst=1 at an edge, from any state): state=IDLE, mem_req=0, mem_we=0, all done pulses 0, starve counter 0, kill flag 0, captured regs 0. An in-flight memory response after reset is ignored.
- Arbitration happens only in IDLE, combinationally; ld_ready and st_ready are 0 outside IDLE. Store priority applies when st_urgent=1 or starve_cnt==STARVE_LIMIT; otherwise load priority. Only the selected requester's ready is 1. ld_ready=0 while flush=1.
- Accept: addr/data/be/tag are captured. Next state is ST_REQ (store) or LD_REQ (load). mem_req=1 from the following cycle and is driven only from registers.
- ST_REQ: hold mem_req=1, mem_we=1 until mem_gnt. On mem_gnt go to IDLE and pulse st_done the next cycle. Stores ignore flush.
- LD_REQ: hold mem_req=1, mem_we=0 until mem_gnt, then go to LD_WAIT. mem_req must not drop before grant, even on flush.
- LD_WAIT: on mem_rvalid go to IDLE. The next cycle pulses ld_done_valid with the captured tag and registered mem_rdata, unless kill=1.
- Kill flag: set by flush in LD_REQ or LD_WAIT, and by flush in the cycle mem_rvalid arrives. Cleared when returning to IDLE.
- Minimum latencies: store, accept→st_done = 2 cycles with a same-cycle grant. Load, accept→ld_done_valid = 3 cycles with a same-cycle grant and next-cycle rvalid. Back-to-back accepts are possible one cycle after leaving to IDLE.
- Starve counter:
  - increments on a load accept while st_valid=1, saturating at STARVE_LIMIT;
  - clears on a store accept;
  - holds otherwise.
- Simultaneous events:
  - flush and ld_valid in IDLE: no accept.
  - mem_gnt and mem_rvalid in the same cycle while in LD_REQ: rvalid is ignored (the protocol guarantees rvalid ≥1 cycle after gnt).
  - rvalid outside LD_WAIT: ignored.

Decomposition:
- Shared package (mem_arb_pkg): state enum, ADDR_W, DATA_W, TAG_W defaults, word-align helper.
- Sub-module mem_arb_pick: combinational priority select plus registered starve counter. Inputs: ld_valid, st_valid, st_urgent, flush, idle, accept strobes. Outputs: ld_ready, st_ready.

Test Plan:
- Single load 0x104, tag 5, gnt immediate, rvalid next cycle with 0xDEADBEEF → mem_addr=0x104, mem_be=4'hF; ld_done_valid 3 cycles after accept, tag 5, data 0xDEADBEEF.
- Store 0x200 data 0x12345678 be 4'h3, gnt held low 3 cycles → mem_req held 4 cycles; st_done one cycle after gnt.
- Continuous ld_valid plus st_valid, STARVE_LIMIT=4 → 4 loads accepted, then a store; counter returns to 0.
- ld_valid and st_valid with st_urgent=1 → store accepted first.
- Flush during LD_WAIT → rvalid consumed, no ld_done_valid, FSM returns to IDLE; next load completes normally.
- rst asserted in LD_REQ → next cycle mem_req=0, busy=0, IDLE; late rvalid produces no output.
